// File: rtl/regfile_psw.sv
// regfile_psw: 8x16 register file with write-through bypass,
// NZVC status word and branch-condition evaluation.
module regfile_psw #(
  parameter int         WIDTH     = 16,
  parameter int         NREGS     = 8,
  parameter int         AW        = 3,
  parameter logic [3:0] PSW_RESET = 4'b0000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [AW-1:0]    RAADDR,
  output logic [WIDTH-1:0] RADATA,
  input  logic [AW-1:0]    RBADDR,
  output logic [WIDTH-1:0] RBDATA,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [3:0]       FLGWE,
  input  logic             NIN,
  input  logic             ZIN,
  input  logic             VIN,
  input  logic             CIN_IN,
  input  logic             PSWLD,
  input  logic [3:0]       PSWIN,
  output logic [3:0]       PSW,
  output logic             CFLAG,
  input  logic [3:0]       COND,
  output logic             TAKEN
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [3:0]       r_psw;

  logic             w_wr;
  logic             w_byp_a;
  logic             w_byp_b;
  logic [3:0]       w_fin;
  logic             w_n;
  logic             w_z;
  logic             w_v;
  logic             w_c;
  logic             w_base;

  // Writes are suppressed while reset is held, so bypass is too.
  assign w_wr    = WE & ~RESET;
  assign w_byp_a = w_wr & (WADDR == RAADDR);
  assign w_byp_b = w_wr & (WADDR == RBADDR);

  assign RADATA = w_byp_a ? WDATA : r_regs[RAADDR];
  assign RBDATA = w_byp_b ? WDATA : r_regs[RBADDR];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (WE) begin
      r_regs[WADDR] <= WDATA;
    end
  end

  assign w_fin = {NIN, ZIN, VIN, CIN_IN};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_psw <= PSW_RESET;
    end else if (PSWLD) begin
      r_psw <= PSWIN;
    end else begin
      r_psw <= (r_psw & ~FLGWE) | (w_fin & FLGWE);
    end
  end

  assign PSW   = r_psw;
  assign CFLAG = r_psw[0];

  assign w_n = r_psw[3];
  assign w_z = r_psw[2];
  assign w_v = r_psw[1];
  assign w_c = r_psw[0];

  always_comb begin
    w_base = 1'b1;
    unique case (COND[2:0])
      3'b000: w_base = 1'b1;
      3'b001: w_base = w_z;
      3'b010: w_base = w_n;
      3'b011: w_base = w_c;
      3'b100: w_base = w_v;
      3'b101: w_base = w_n ^ w_v;
      3'b110: w_base = (w_n ^ w_v) | w_z;
      3'b111: w_base = w_c | w_z;
    endcase
  end

  assign TAKEN = w_base ^ COND[3];

endmodule

// File: tb/tb_regfile_psw.sv
// tb_regfile_psw: directed and random checks of regfile_psw
// against an array-based reference model.
module tb_regfile_psw;

  logic        CLK;
  logic        RESET;
  logic [2:0]  RAADDR;
  logic [15:0] RADATA;
  logic [2:0]  RBADDR;
  logic [15:0] RBDATA;
  logic        WE;
  logic [2:0]  WADDR;
  logic [15:0] WDATA;
  logic [3:0]  FLGWE;
  logic        NIN;
  logic        ZIN;
  logic        VIN;
  logic        CIN_IN;
  logic        PSWLD;
  logic [3:0]  PSWIN;
  logic [3:0]  PSW;
  logic        CFLAG;
  logic [3:0]  COND;
  logic        TAKEN;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  logic [15:0] m_regs [8];
  logic [3:0]  m_psw;
  logic [3:0]  fin;

  regfile_psw dut (
    .CLK(CLK), .RESET(RESET),
    .RAADDR(RAADDR), .RADATA(RADATA),
    .RBADDR(RBADDR), .RBDATA(RBDATA),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .FLGWE(FLGWE), .NIN(NIN), .ZIN(ZIN),
    .VIN(VIN), .CIN_IN(CIN_IN),
    .PSWLD(PSWLD), .PSWIN(PSWIN), .PSW(PSW),
    .CFLAG(CFLAG), .COND(COND), .TAKEN(TAKEN)
  );

  initial begin
    CLK = 0;
    forever #10 CLK = ~CLK;
  end

  assign fin = {NIN, ZIN, VIN, CIN_IN};

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0;
      m_psw <= 4'b0000;
    end else begin
      if (WE) m_regs[WADDR] <= WDATA;
      if (PSWLD) m_psw <= PSWIN;
      else
        for (int i = 0; i < 4; i++)
          if (FLGWE[i]) m_psw[i] <= fin[i];
    end
  end

  function automatic logic [15:0] exp_rd(logic [2:0] a);
    if (RESET) return 16'h0;
    if (WE && WADDR == a) return WDATA;
    return m_regs[a];
  endfunction

  function automatic logic m_taken(logic [3:0] p, logic [3:0] c);
    logic n, z, v, cy, lt;
    logic r;
    n = p[3]; z = p[2]; v = p[1]; cy = p[0];
    lt = (n != v);
    case (c[2:0])
      3'd0: r = 1'b1;
      3'd1: r = z;
      3'd2: r = n;
      3'd3: r = cy;
      3'd4: r = v;
      3'd5: r = lt;
      3'd6: r = lt || z;
      default: r = cy || z;
    endcase
    return c[3] ? !r : r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (started) begin
      chk("cmp_radata", {16'h0, RADATA}, {16'h0, exp_rd(RAADDR)});
      chk("cmp_rbdata", {16'h0, RBDATA}, {16'h0, exp_rd(RBADDR)});
      chk("cmp_psw", {28'h0, PSW}, {28'h0, m_psw});
      chk("cmp_cflag", {31'h0, CFLAG}, {31'h0, m_psw[0]});
      chk("cmp_taken", {31'h0, TAKEN}, {31'h0, m_taken(m_psw, COND)});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic loadpsw(logic [3:0] p);
    PSWLD = 1; PSWIN = p;
    step();
    PSWLD = 0;
    #1;
  endtask

  initial begin
    RESET = 1; RAADDR = 0; RBADDR = 0; WE = 0; WADDR = 0;
    WDATA = 0; FLGWE = 0; NIN = 0; ZIN = 0; VIN = 0;
    CIN_IN = 0; PSWLD = 0; PSWIN = 0; COND = 0;
    #25;
    RESET = 0;
    started = 1;

    // 1: async reset after writes
    step();
    WE = 1; WADDR = 2; WDATA = 16'h1234;
    FLGWE = 4'b1111; {NIN, ZIN, VIN, CIN_IN} = 4'b1111;
    step();
    WADDR = 5; WDATA = 16'h0055; FLGWE = 0;
    step();
    WE = 0; RAADDR = 2; RBADDR = 5;
    #1;
    chk("pre_rst_a", {16'h0, RADATA}, 32'h1234);
    chk("pre_rst_psw", {28'h0, PSW}, 32'hF);
    #1 RESET = 1;
    COND = 4'b0000;
    #1;
    chk("rst_radata", {16'h0, RADATA}, 32'h0);
    chk("rst_rbdata", {16'h0, RBDATA}, 32'h0);
    chk("rst_psw", {28'h0, PSW}, 32'h0);
    chk("rst_cflag", {31'h0, CFLAG}, 32'h0);
    chk("rst_always", {31'h0, TAKEN}, 32'h1);
    COND = 4'b1000;
    #1;
    chk("rst_never", {31'h0, TAKEN}, 32'h0);
    RESET = 0;
    {NIN, ZIN, VIN, CIN_IN} = 4'b0000;

    // 2: write with bypass, then registered read
    step();
    WE = 1; WADDR = 3; WDATA = 16'hBEEF;
    RAADDR = 3; RBADDR = 4;
    #1;
    chk("byp_a", {16'h0, RADATA}, 32'hBEEF);
    chk("no_byp_b", {16'h0, RBDATA}, 32'h0);
    step();
    WE = 0; RAADDR = 3; RBADDR = 3;
    #1;
    chk("rd_a3", {16'h0, RADATA}, 32'hBEEF);
    chk("rd_b3", {16'h0, RBDATA}, 32'hBEEF);
    RAADDR = 4;
    #1;
    chk("rd_a4", {16'h0, RADATA}, 32'h0);

    // 3: flag masks and load priority
    FLGWE = 4'b1011; {NIN, ZIN, VIN, CIN_IN} = 4'b1111;
    step();
    FLGWE = 4'b0100; {NIN, ZIN, VIN, CIN_IN} = 4'b0100;
    #1;
    chk("flg_1011", {28'h0, PSW}, 32'hB);
    step();
    #1;
    chk("flg_1111", {28'h0, PSW}, 32'hF);
    PSWLD = 1; PSWIN = 4'b0010; FLGWE = 4'b1111;
    {NIN, ZIN, VIN, CIN_IN} = 4'b1111;
    step();
    PSWLD = 0; FLGWE = 0;
    #1;
    chk("ld_wins", {28'h0, PSW}, 32'h2);

    // 4: carry visible one cycle after update
    FLGWE = 4'b0001; CIN_IN = 1;
    #1;
    chk("cf_same", {31'h0, CFLAG}, 32'h0);
    step();
    FLGWE = 0;
    #1;
    chk("cf_next", {31'h0, CFLAG}, 32'h1);

    // 5: condition codes
    loadpsw(4'b1000);
    COND = 4'b0101; #1;
    chk("lt_n", {31'h0, TAKEN}, 32'h1);
    COND = 4'b1101; #1;
    chk("ge_n", {31'h0, TAKEN}, 32'h0);
    loadpsw(4'b0001);
    COND = 4'b0111; #1;
    chk("ule_c", {31'h0, TAKEN}, 32'h1);
    COND = 4'b0011; #1;
    chk("cs_c", {31'h0, TAKEN}, 32'h1);
    loadpsw(4'b1010);
    COND = 4'b0101; #1;
    chk("lt_nv", {31'h0, TAKEN}, 32'h0);
    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < 16; c++) begin
        PSWLD = 1; PSWIN = 4'(p); COND = 4'(c);
        step();
        PSWLD = 0;
        #1;
        chk("sweep", {31'h0, TAKEN}, {31'h0, m_taken(4'(p), 4'(c))});
      end
    end

    // 6: random traffic with reset pulses
    for (int k = 0; k < 10000; k++) begin
      WE = 1'($urandom);
      WADDR = 3'($urandom);
      WDATA = 16'($urandom);
      RAADDR = 3'($urandom);
      RBADDR = ($urandom_range(0, 3) == 0) ? WADDR : 3'($urandom);
      FLGWE = 4'($urandom);
      {NIN, ZIN, VIN, CIN_IN} = 4'($urandom);
      PSWLD = ($urandom_range(0, 7) == 0);
      PSWIN = 4'($urandom);
      COND = 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 RESET = 1;
        #2 RESET = 0;
      end
      step();
    end
    WE = 0; FLGWE = 0; PSWLD = 0;
    step();
    started = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
